clap_detector_param: RTL and testbench

Parametrised successor to the single-threshold clap detector in the audio input path of the home-simulation design. Operates on signed PCM samples qualified by a valid strobe and compares the sample magnitude against a runtime threshold. Requires a run of consecutive loud samples before declaring a clap, then enforces a refractory holdoff. Outputs a one-cycle clap pulse and a saturating clap counter for the keyboard/display control logic.

---
 rtl/clap_detector_param_if.sv | 24 ++
 rtl/clap_detector_param.sv | 173 +++++++++++++++++
 tb/tb_clap_detector_param.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/clap_detector_param_if.sv
// Audio-side bus of the clap detector: sample stream and threshold in, clap events out.
interface clap_detector_param_if #(
    parameter int SAMPLE_W = 24,
    parameter int CNT_W    = 8
);
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] sample;
    logic        [SAMPLE_W-2:0] threshold;
    logic                       enable;
    logic                       clap_pulse;
    logic        [CNT_W-1:0]    clap_count;
    logic                       busy;
    logic                       double_clap;

    modport master (
        output sample_valid, sample, threshold, enable,
        input  clap_pulse, clap_count, busy, double_clap
    );

    modport slave (
        input  sample_valid, sample, threshold, enable,
        output clap_pulse, clap_count, busy, double_clap
    );
endinterface

// File: rtl/clap_detector_param.sv
// Clap detector: run of loud samples -> one-cycle pulse, saturating count, refractory holdoff.
// Optional double-clap window enabled by defining CLAP_DOUBLE_EN.
module clap_detector_param #(
    parameter int SAMPLE_W   = 24,
    parameter int MIN_HITS   = 4,
    parameter int HOLDOFF    = 4800,
    parameter int CNT_W      = 8,
    parameter int DOUBLE_WIN = 24000
) (
    input  logic                  clk,
    input  logic                  resetn,
    clap_detector_param_if.slave  bus
);
    localparam int HIT_W  = $clog2(MIN_HITS + 1);
    localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DETECT  = 2'd1,
        FIRE    = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [HIT_W-1:0]    hit_q, hit_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                pulse_q, pulse_d;
    logic                fire_enter;

    logic [SAMPLE_W-1:0] neg_s;
    logic [SAMPLE_W-2:0] mag;
    logic                qual;

    // The most negative sample has no positive twin; clamp it to full scale.
    always_comb begin
        neg_s = ~bus.sample + {{(SAMPLE_W-1){1'b0}}, 1'b1};
        mag   = bus.sample[SAMPLE_W-2:0];
        if (bus.sample[SAMPLE_W-1]) begin
            if (bus.sample[SAMPLE_W-2:0] == '0) begin
                mag = '1;
            end else begin
                mag = neg_s[SAMPLE_W-2:0];
            end
        end
        qual = bus.sample_valid && (mag > bus.threshold);
    end

    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (qual) begin
                    hit_d   = HIT_W'(1);
                    state_d = (MIN_HITS == 1) ? FIRE : DETECT;
                end
            end
            DETECT: begin
                if (bus.sample_valid) begin
                    if (qual) begin
                        hit_d = hit_q + HIT_W'(1);
                        if (hit_q >= HIT_W'(MIN_HITS - 1)) begin
                            state_d = FIRE;
                        end
                    end else begin
                        hit_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            FIRE: begin
                hit_d = '0;
                if (HOLDOFF == 0) begin
                    hold_d  = '0;
                    state_d = IDLE;
                end else begin
                    hold_d  = HOLD_W'(HOLDOFF);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.sample_valid) begin
                    if (hold_q <= HOLD_W'(1)) begin
                        hold_d  = '0;
                        state_d = IDLE;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                hit_d   = '0;
                hold_d  = '0;
            end
        endcase

        if (!bus.enable) begin
            state_d = IDLE;
            hit_d   = '0;
            hold_d  = '0;
        end

        // FIRE never follows itself, so entering it is just "next is FIRE".
        fire_enter = (state_d == FIRE);
        pulse_d    = fire_enter;
        count_d    = count_q;
        if (fire_enter && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            hit_q   <= '0;
            hold_q  <= '0;
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            hold_q  <= hold_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef CLAP_DOUBLE_EN
    localparam int WIN_W = (DOUBLE_WIN > 0) ? $clog2(DOUBLE_WIN + 1) : 1;

    logic [WIN_W-1:0] win_q, win_d;
    logic             dbl_q, dbl_d;

    // The window is checked before it reloads, so a third clap opens a fresh window.
    always_comb begin
        win_d = win_q;
        dbl_d = 1'b0;
        if (!bus.enable) begin
            win_d = '0;
        end else if (fire_enter) begin
            if (win_q != '0) begin
                dbl_d = 1'b1;
                win_d = '0;
            end else begin
                win_d = WIN_W'(DOUBLE_WIN);
            end
        end else if (bus.sample_valid && (state_q != FIRE) && (win_q != '0)) begin
            win_d = win_q - WIN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            win_q <= '0;
            dbl_q <= 1'b0;
        end else begin
            win_q <= win_d;
            dbl_q <= dbl_d;
        end
    end

    assign bus.double_clap = dbl_q;
`else
    assign bus.double_clap = 1'b0;
`endif

    assign bus.clap_pulse = pulse_q;
    assign bus.clap_count = count_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_clap_detector_param.sv
// Scoreboard bench for clap_detector_param (SAMPLE_W=8, MIN_HITS=3, HOLDOFF=5, CNT_W=2, DOUBLE_WIN=20).
module tb_clap_detector_param;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    clap_detector_param_if #(.SAMPLE_W(8), .CNT_W(2)) bus ();

    clap_detector_param #(
        .SAMPLE_W(8), .MIN_HITS(3), .HOLDOFF(5), .CNT_W(2), .DOUBLE_WIN(20)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        int cyc;
        int cnt;
        bit dbl;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   tests   = 0;
    int   fails   = 0;
    int   exp_cnt = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(string name, int act, int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send(bit v, int s);
        bus.sample_valid = v;
        bus.sample       = 8'(s);
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
    endtask

    // Called right after the edge that samples the last hit: the pulse belongs to this cycle.
    task automatic expect_clap(bit dbl);
        exp_t e;
        exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
        e.cyc = cyc;
        e.cnt = exp_cnt;
        e.dbl = dbl;
        q.push_back(e);
    endtask

    task automatic clap(bit dbl);
        send(1, 20);
        send(1, -20);
        send(1, 20);
        expect_clap(dbl);
        send(0, 0);
    endtask

    task automatic holdoff();
        for (int i = 0; i < 5; i++) send(1, 100);
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   want_dbl;
        if (resetn && (bus.clap_pulse || bus.double_clap)) begin
            if (q.size() == 0) begin
                tests = tests + 1;
                fails = fails + 1;
                $display("FAIL unexpected_pulse: pulse=%0d double=%0d count=%0d at cycle %0d, expected no pulse",
                         bus.clap_pulse, bus.double_clap, bus.clap_count, cyc);
            end else begin
                e = q.pop_front();
`ifdef CLAP_DOUBLE_EN
                want_dbl = e.dbl;
`else
                want_dbl = 1'b0;
`endif
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_high", int'(bus.clap_pulse), 1);
                check("pulse_count", int'(bus.clap_count), e.cnt);
                check("double_clap", int'(bus.double_clap), int'(want_dbl));
            end
        end
    end

    initial begin
        resetn           = 1'b0;
        bus.enable       = 1'b1;
        bus.threshold    = 7'd16;
        bus.sample_valid = 1'b0;
        bus.sample       = '0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        check("rst_pulse", int'(bus.clap_pulse), 0);
        check("rst_count", int'(bus.clap_count), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_double", int'(bus.double_clap), 0);

        // Basic clap, then holdoff ignores loud samples
        clap(0);
        for (int i = 0; i < 5; i++) begin
            send(1, 100);
            check("busy_holdoff", int'(bus.busy), (i < 4) ? 1 : 0);
        end

        // Threshold is strict; then full-scale negative saturates
        send(1, 20); send(1, 20); send(1, 16); send(1, 20); send(1, 20);
        send(1, 0);
        check("busy_after_break", int'(bus.busy), 0);
        send(1, -128); send(1, -128); send(1, -128);
        expect_clap(1);
        send(0, 0);
        holdoff();

        // Gaps without valid do not break the run
        send(1, 20);
        send(0, 0); send(0, 0); send(0, 0);
        send(1, 20); send(1, 20);
        expect_clap(0);
        send(0, 0);
        holdoff();
        check("count_before_enable", int'(bus.clap_count), 3);

        // enable=0 aborts a run without counting
        send(1, 20); send(1, 20);
        bus.enable = 1'b0;
        send(0, 0);
        check("enable_busy", int'(bus.busy), 0);
        check("enable_count", int'(bus.clap_count), 3);
        bus.enable = 1'b1;
        send(1, 20);
        check("enable_restart_busy", int'(bus.busy), 1);
        send(1, 0);
        check("enable_restart_idle", int'(bus.busy), 0);

        // Saturating counter over five claps
        resetn = 1'b0;
        send(0, 0);
        resetn  = 1'b1;
        exp_cnt = 0;
        check("rst2_count", int'(bus.clap_count), 0);
        clap(0); holdoff();
        clap(1); holdoff();
        clap(0); holdoff();
        clap(1); holdoff();
        clap(0);
        send(1, 100); send(1, 100);
        check("mid_holdoff_busy", int'(bus.busy), 1);
        resetn = 1'b0;
        send(0, 0);
        check("rst_mid_count", int'(bus.clap_count), 0);
        check("rst_mid_busy", int'(bus.busy), 0);
        resetn  = 1'b1;
        exp_cnt = 0;

        // Double-clap window: 10 samples apart, then 25 apart
        clap(0); holdoff();
        send(1, 0); send(1, 0);
        clap(1); holdoff();
        clap(0); holdoff();
        for (int i = 0; i < 17; i++) send(1, 0);
        clap(0); holdoff();

        repeat (5) send(0, 0);
        check("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
